// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one shared 8-way resource: registered grant index/enable
// for a 3-to-8 gated decoder, matching one-hot grant, hold timeout and owner gap.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; picks next requester after `last` when req != 0
// ST_GRANT | gnt_idx owns the resource until done, request drop or timeout
module rr_arbiter8 #(
   parameter int HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [2:0] gnt_idx,
   output logic       gnt_en,
   output logic [7:0] gnt,
   output logic       expired
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Last counter value an owner may reach; unused when the timeout is off.
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
   localparam logic       HOLD_ON   = (HOLD_MAX != 0);

   logic [0:0] state;
   logic [7:0] hold_cnt;
   logic [2:0] last;
   logic [2:0] winner;
   logic [2:0] cand;
   logic       found;
   logic       rel_drop;
   logic       rel_to;
   logic       rel_any;

   // Scan starts just past the previous owner so it gets the lowest priority.
   always_comb begin
      winner = last;
      cand   = '0;
      found  = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cand = last + 3'(i);
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   assign rel_drop = ~req[gnt_idx];
   assign rel_to   = HOLD_ON && (hold_cnt == HOLD_LAST);
   assign rel_any  = done | rel_drop | rel_to;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         hold_cnt <= 8'd0;
         last     <= 3'd7;
         gnt_idx  <= 3'd0;
         gnt_en   <= 1'b0;
         gnt      <= 8'd0;
         expired  <= 1'b0;
      end else begin
         expired <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  gnt_idx  <= winner;
                  gnt_en   <= 1'b1;
                  gnt      <= 8'b1 << winner;
                  hold_cnt <= 8'd0;
                  state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (rel_any) begin
                  gnt_en  <= 1'b0;
                  gnt     <= 8'd0;
                  last    <= gnt_idx;
                  state   <= ST_IDLE;
                  // An explicit release or request drop wins over the timeout flag.
                  expired <= rel_to & ~done & ~rel_drop;
               end else if (hold_cnt != 8'hFF) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: expected grants queued as stimulus is applied,
// popped and compared one cycle later after the clock edge.
module tb_rr_arbiter8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'd0;
   logic       done = 1'b0;

   logic [2:0] gnt_idx;
   logic       gnt_en;
   logic [7:0] gnt;
   logic       expired;

   logic [2:0] u_gnt_idx;
   logic       u_gnt_en;
   logic [7:0] u_gnt;
   logic       u_expired;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       en;
      logic [2:0] idx;
      logic       xp;
      logic       chk_u;
      logic [7:0] u_gnt;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   rr_arbiter8 #(.HOLD_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .gnt_idx(gnt_idx), .gnt_en(gnt_en), .gnt(gnt), .expired(expired)
   );

   rr_arbiter8 #(.HOLD_MAX(0)) dut_u (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .gnt_idx(u_gnt_idx), .gnt_en(u_gnt_en), .gnt(u_gnt), .expired(u_expired)
   );

   task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [7:0] r, input logic d, input logic en,
                       input logic [2:0] idx, input logic xp,
                       input logic cu, input logic [7:0] ug);
      exp_t e;
      req  = r;
      done = d;
      e.en = en; e.idx = idx; e.xp = xp; e.chk_u = cu; e.u_gnt = ug;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: observed empty queue required one entry");
      end else begin
         e = sb.pop_front();
         cmp("gnt_en",  {7'd0, gnt_en},  {7'd0, e.en});
         cmp("gnt_idx", {5'd0, gnt_idx}, {5'd0, e.idx});
         cmp("gnt",     gnt,             e.en ? (8'b1 << e.idx) : 8'd0);
         cmp("expired", {7'd0, expired}, {7'd0, e.xp});
         if (e.chk_u) begin
            cmp("u_gnt",     u_gnt,             e.u_gnt);
            cmp("u_expired", {7'd0, u_expired}, 8'd0);
         end
      end
   endtask

   task automatic check_reset(input string tag);
      cmp({tag, "_gnt"},     gnt,              8'd0);
      cmp({tag, "_gnt_en"},  {7'd0, gnt_en},   8'd0);
      cmp({tag, "_gnt_idx"}, {5'd0, gnt_idx},  8'd0);
      cmp({tag, "_expired"}, {7'd0, expired},  8'd0);
   endtask

   initial begin
      #12;
      check_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // single requester, done after three grant cycles, regrant, drop
      step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00);
      step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00);
      step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00);
      step(8'h01, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
      step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00);
      step(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
      step(8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00);

      // hold timeout at 4 cycles, regrant, then done exactly at the limit
      step(8'h04, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
      step(8'h04, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
      step(8'h04, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
      step(8'h04, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
      step(8'h04, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'h00);
      step(8'h04, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
      step(8'h04, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
      step(8'h04, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
      step(8'h04, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
      step(8'h04, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 8'h00);
      step(8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 8'h00);

      // fresh pointer, all requesting: 0..7,0 with a gap after each grant
      rst_n = 1'b0;
      #1;
      check_reset("rst2");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step(8'hFF, 1'b0, 1'b1, 3'(k), 1'b0, 1'b0, 8'h00);
         step(8'hFF, 1'b1, 1'b0, 3'(k), 1'b0, 1'b0, 8'h00);
      end

      // owner 5 drops its request, index held through gap, wrap to 0
      step(8'h21, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 8'h00);
      step(8'h01, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 8'h00);
      step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00);
      step(8'h01, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00);

      // asynchronous reset while requester 3 owns the grant
      step(8'h08, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'h00);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("async_rst");
      req = 8'h88;
      @(negedge clk);
      rst_n = 1'b1;

      // pointer back at 7 gives 3; timeout rotates to 7; unlimited instance keeps 3
      step(8'h88, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 8'h08);
      step(8'h88, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 8'h08);
      step(8'h88, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 8'h08);
      step(8'h88, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 8'h08);
      step(8'h88, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 8'h08);
      step(8'h88, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 8'h08);
      step(8'h88, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 8'h08);
      step(8'h00, 1'b1, 1'b0, 3'd7, 1'b0, 1'b1, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
